// File: rtl/alu_seq.sv
// alu_seq: issue/retire sequencer in front of an N-bit ALU; holds operands, times the enable, formats and flags the result.
module alu_seq #(
  parameter int N = 32,
  parameter int COMB_LAT = 1,
  parameter int SHIFT_LAT = 1,
  parameter int MUL_LAT = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [2:0]     in_op,
  output logic           alu_en,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [2:0]     alu_op,
  input  logic [2*N-1:0] alu_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_y,
  output logic [2:0]     out_flag
);
  localparam int MAXL = (MUL_LAT > COMB_LAT ? (MUL_LAT > SHIFT_LAT ? MUL_LAT : SHIFT_LAT)
                                            : (COMB_LAT > SHIFT_LAT ? COMB_LAT : SHIFT_LAT));
  localparam int CW = $clog2(MAXL + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_lat;
  logic [2*N-1:0] w_fmt_y;
  logic [2:0] w_flag;
  logic w_accept, w_last, w_addsub, w_mul;
  always_comb begin
    w_accept = (r_state == IDLE) && in_valid;
    w_last = r_cnt == CW'(1);
    w_next = r_state == IDLE ? (in_valid ? EXEC : IDLE) :
             r_state == EXEC ? (w_last ? DONE : EXEC) :
             (out_ready ? IDLE : DONE);
    w_lat = in_op == 3'b111 ? CW'(MUL_LAT) :
            (in_op[2] && (in_op[1] || in_op[0])) ? CW'(SHIFT_LAT) : CW'(COMB_LAT);
    w_addsub = alu_op[2:1] == 2'b00;
    w_mul = alu_op == 3'b111;
    // add/sub keep the carry/borrow bit just above the N-bit sum
    w_fmt_y = w_mul ? alu_y :
              w_addsub ? {{(N-1){1'b0}}, alu_y[N:0]} : {{N{1'b0}}, alu_y[N-1:0]};
    w_flag = {w_addsub & alu_y[N], w_mul ? alu_y[2*N-1] : alu_y[N-1], ~|w_fmt_y};
  end
  assign in_ready = r_state == IDLE;
  assign alu_en = r_state == EXEC;
  assign out_valid = r_state == DONE;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      r_cnt <= '0;
      out_y <= '0;
      out_flag <= '0;
    end else begin
      if (w_accept) begin
        alu_a <= in_a;
        alu_b <= in_b;
        alu_op <= in_op;
        r_cnt <= w_lat;
      end else if (r_state == EXEC) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == EXEC && w_last) begin
        out_y <= w_fmt_y;
        out_flag <= w_flag;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at N=8, MUL_LAT=8 with a behavioural ALU fed back on alu_y.
module tb_alu_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, alu_en, out_valid;
  logic [7:0] in_a = 0, in_b = 0, alu_a, alu_b;
  logic [2:0] in_op = 0, alu_op, out_flag;
  logic [15:0] alu_y, out_y;
  int n_chk = 0, n_pass = 0;
  alu_seq #(.N(8), .COMB_LAT(1), .SHIFT_LAT(1), .MUL_LAT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .alu_en(alu_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flag(out_flag)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_y = 16'h0000;
    case (alu_op)
      3'b000: alu_y = {8'h00, alu_a} + {8'h00, alu_b};
      3'b001: alu_y = {8'h00, alu_a} - {8'h00, alu_b};
      3'b010: alu_y = {8'h00, alu_a & alu_b};
      3'b011: alu_y = {8'h00, alu_a | alu_b};
      3'b100: alu_y = {8'h00, ~alu_a};
      3'b101: alu_y = {8'h00, alu_a << alu_b[2:0]};
      3'b110: alu_y = {8'h00, alu_a >> alu_b[2:0]};
      default: alu_y = alu_a * alu_b;
    endcase
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = 1; in_a = a; in_b = b; in_op = op;
    step();
    in_valid = 0;
  endtask
  task automatic wait_done(output int t);
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
  endtask
  task automatic test_reset();
    rst = 1;
    step(); step();
    rst = 0;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_chk++; if (alu_en !== 1'b0) $display("FAIL reset_alu_en got %b want 0", alu_en); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_y !== 16'h0000 || out_flag !== 3'b000) $display("FAIL reset_out got %h/%b want 0000/000", out_y, out_flag); else n_pass++;
    n_chk++; if ({alu_a, alu_b, alu_op} !== 19'd0) $display("FAIL reset_alu_in got %h %h %b want 0", alu_a, alu_b, alu_op); else n_pass++;
  endtask
  task automatic test_add();
    out_ready = 1;
    issue(8'hF0, 8'h20, 3'b000);
    n_chk++; if ({alu_en, in_ready, out_valid} !== 3'b100) $display("FAIL add_exec en/rdy/vld got %b want 100", {alu_en, in_ready, out_valid}); else n_pass++;
    step();
    n_chk++; if ({alu_en, out_valid} !== 2'b01) $display("FAIL add_done en/vld got %b want 01", {alu_en, out_valid}); else n_pass++;
    n_chk++; if (out_y !== 16'h0110) $display("FAIL add_y got %h want 0110", out_y); else n_pass++;
    n_chk++; if (out_flag !== 3'b100) $display("FAIL add_flag got %b want 100", out_flag); else n_pass++;
    step();
    n_chk++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL add_retire rdy/vld got %b want 10", {in_ready, out_valid}); else n_pass++;
  endtask
  task automatic test_mul();
    int t, en_cnt;
    out_ready = 1;
    issue(8'h0F, 8'h11, 3'b111);
    t = 0; en_cnt = 0;
    while (!out_valid && t < 20) begin
      if (alu_en) en_cnt++;
      n_chk++; if (alu_a !== 8'h0F || alu_op !== 3'b111) $display("FAIL mul_hold got %h/%b want 0f/111", alu_a, alu_op); else n_pass++;
      step();
      t++;
    end
    n_chk++; if (en_cnt !== 8) $display("FAIL mul_en_cycles got %0d want 8", en_cnt); else n_pass++;
    n_chk++; if (t !== 8) $display("FAIL mul_latency got %0d want 8", t); else n_pass++;
    n_chk++; if (out_y !== 16'h00FF || out_flag !== 3'b000) $display("FAIL mul_out got %h/%b want 00ff/000", out_y, out_flag); else n_pass++;
    step();
    issue(8'h90, 8'h02, 3'b111);
    wait_done(t);
    n_chk++; if (out_y !== 16'h0120 || out_flag !== 3'b000) $display("FAIL mul2_out got %h/%b want 0120/000", out_y, out_flag); else n_pass++;
    step();
    issue(8'hFF, 8'hFF, 3'b111);
    wait_done(t);
    n_chk++; if (out_y !== 16'hFE01 || out_flag !== 3'b010) $display("FAIL mul3_out got %h/%b want fe01/010", out_y, out_flag); else n_pass++;
    step();
  endtask
  task automatic test_sub_zero();
    int t;
    issue(8'h05, 8'h05, 3'b001);
    wait_done(t);
    n_chk++; if (t !== 1) $display("FAIL sub_latency got %0d want 1", t); else n_pass++;
    n_chk++; if (out_y !== 16'h0000 || out_flag !== 3'b001) $display("FAIL sub_zero got %h/%b want 0000/001", out_y, out_flag); else n_pass++;
    step();
    issue(8'h03, 8'h05, 3'b001);
    wait_done(t);
    n_chk++; if (out_y !== 16'h01FE || out_flag !== 3'b110) $display("FAIL sub_borrow got %h/%b want 01fe/110", out_y, out_flag); else n_pass++;
    step();
  endtask
  task automatic test_logic();
    int t;
    issue(8'h0F, 8'h00, 3'b100);
    wait_done(t);
    n_chk++; if (out_y !== 16'h00F0 || out_flag !== 3'b010) $display("FAIL not_out got %h/%b want 00f0/010", out_y, out_flag); else n_pass++;
    step();
    issue(8'h81, 8'h01, 3'b101);
    wait_done(t);
    n_chk++; if (out_y !== 16'h0002 || out_flag !== 3'b000 || t !== 1) $display("FAIL lsh_out got %h/%b/%0d want 0002/000/1", out_y, out_flag, t); else n_pass++;
    step();
    issue(8'h80, 8'h07, 3'b110);
    wait_done(t);
    n_chk++; if (out_y !== 16'h0001 || out_flag !== 3'b000) $display("FAIL rsh_out got %h/%b want 0001/000", out_y, out_flag); else n_pass++;
    step();
  endtask
  task automatic test_backpressure();
    out_ready = 0;
    issue(8'h01, 8'h02, 3'b000);
    step();
    in_valid = 1; in_a = 8'h33; in_b = 8'h44; in_op = 3'b010;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_hs_%0d vld/rdy got %b want 10", i, {out_valid, in_ready}); else n_pass++;
      n_chk++; if (out_y !== 16'h0003 || alu_a !== 8'h01) $display("FAIL bp_hold_%0d got %h/%h want 0003/01", i, out_y, alu_a); else n_pass++;
      step();
    end
    out_ready = 1;
    step();
    n_chk++; if ({out_valid, in_ready} !== 2'b01 || alu_a !== 8'h01) $display("FAIL bp_retire_only got %b/%h want 01/01", {out_valid, in_ready}, alu_a); else n_pass++;
    step();
    in_valid = 0;
    n_chk++; if (alu_a !== 8'h33 || alu_en !== 1'b1) $display("FAIL bp_accept got %h/%b want 33/1", alu_a, alu_en); else n_pass++;
    step();
    n_chk++; if (out_y !== 16'h0000 || out_flag !== 3'b001) $display("FAIL bp_second got %h/%b want 0000/001", out_y, out_flag); else n_pass++;
    step();
  endtask
  task automatic test_reset_mid();
    logic seen;
    issue(8'h03, 8'h04, 3'b111);
    step(); step(); step();
    rst = 1;
    step();
    rst = 0;
    n_chk++; if ({in_ready, alu_en, out_valid} !== 3'b100) $display("FAIL rmid_state rdy/en/vld got %b want 100", {in_ready, alu_en, out_valid}); else n_pass++;
    n_chk++; if (out_y !== 16'h0000 || alu_op !== 3'b000 || alu_a !== 8'h00) $display("FAIL rmid_regs got %h/%b/%h want 0000/000/00", out_y, alu_op, alu_a); else n_pass++;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      seen |= out_valid | alu_en;
      step();
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL rmid_no_retire got %b want 0", seen); else n_pass++;
  endtask
  task automatic test_back_to_back();
    longint t0;
    out_ready = 1;
    issue(8'hAA, 8'h0F, 3'b010);
    step();
    t0 = $time;
    n_chk++; if (out_valid !== 1'b1 || out_y !== 16'h000A) $display("FAIL b2b_and got %b/%h want 1/000a", out_valid, out_y); else n_pass++;
    step();
    issue(8'hAA, 8'h0F, 3'b011);
    step();
    n_chk++; if (out_valid !== 1'b1 || out_y !== 16'h00AF) $display("FAIL b2b_or got %b/%h want 1/00af", out_valid, out_y); else n_pass++;
    n_chk++; if ($time - t0 !== 30) $display("FAIL b2b_spacing got %0d want 30", $time - t0); else n_pass++;
    step();
  endtask
  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub_zero();
    test_logic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
